// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter in front of the single-ported internal RAM/GPIO block
//
// Purpose:
//   Shares one RAM/GPIO port between instruction fetch (port I) and the
//   load/store unit (port D). One access is in flight at a time. The winning
//   request is latched into the mem_* registers and checked for alignment.
//   A bad request is answered directly with an error and never reaches the RAM.
//   A good request strobes mem_enable for one cycle, then waits for mem_valid.
//   The wait is bounded by a timeout.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   i_req/i_addr/i_oplen      port I request (read only)
//   i_done/i_rdata/i_err      port I completion pulse, read data, error flag
//   d_req/d_addr/d_oplen      port D request
//   d_we/d_wdata              port D write enable and write data
//   d_done/d_rdata/d_err      port D completion pulse, read data, error flag
//   mem_enable                one-cycle access strobe to the RAM
//   mem_addr/mem_oplen        latched access address and size
//   mem_we/mem_data           latched write enable and write data
//   mem_valid/mem_result      RAM completion and read data
//
// Configuration:
//   RAM_ARB_ROUND_ROBIN_EN    when defined, simultaneous requests alternate
//                             between ports. When undefined, port D always
//                             has fixed priority.

module ram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [31:0] MMIO_ADDR      = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_oplen,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_oplen,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_oplen,
  output logic        mem_we,
  output logic [31:0] mem_data,
  input  logic        mem_valid,
  input  logic [31:0] mem_result
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_d_q;   // 1: port D owns the current access
  logic        err_q;       // error status reported with done
  logic [7:0]  cnt_q;       // WAIT cycles spent without mem_valid

  logic        any_req;
  logic        gnt_d;
  logic [31:0] sel_addr;
  logic [1:0]  sel_oplen;
  logic        req_bad;
  logic        timeout_hit;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic        last_d_q;    // 1: port D was granted last
`endif

  assign any_req = i_req | d_req;

  // Winner selection. It only matters in IDLE, because requests are not
  // sampled in any other state.
  always_comb begin
    gnt_d = d_req;
    if (i_req && d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      gnt_d = ~last_d_q;
`else
      gnt_d = 1'b1;
`endif
    end
  end

  assign sel_addr  = gnt_d ? d_addr  : i_addr;
  assign sel_oplen = gnt_d ? d_oplen : i_oplen;

  // A reserved size is always an error. The GPIO address takes any size,
  // so it skips the alignment check.
  always_comb begin
    req_bad = 1'b0;
    if (sel_oplen == 2'd3) begin
      req_bad = 1'b1;
    end else if (sel_addr != MMIO_ADDR) begin
      req_bad = ((sel_oplen == 2'd1) && sel_addr[0]) ||
                ((sel_oplen == 2'd2) && (sel_addr[1:0] != 2'b00));
    end
  end

  // The counter holds the number of empty WAIT cycles already spent. The
  // current empty cycle is the last one allowed.
  assign timeout_hit = (cnt_q == (TIMEOUT_LIMIT - 8'd1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = req_bad ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_valid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_enable = (state_q == ISSUE);
    i_done     = (state_q == RESP) && !owner_d_q;
    d_done     = (state_q == RESP) &&  owner_d_q;
    i_err      = i_done && err_q;
    d_err      = d_done && err_q;
  end

  // Datapath: grant latch, wait counter, read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
      mem_addr  <= 32'd0;
      mem_oplen <= 2'd0;
      mem_we    <= 1'b0;
      mem_data  <= 32'd0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_d_q <= gnt_d;
            err_q     <= req_bad;
            mem_addr  <= sel_addr;
            mem_oplen <= sel_oplen;
            mem_we    <= gnt_d & d_we;
            // Port I never writes, so mem_data keeps the last D write data.
            if (gnt_d) mem_data <= d_wdata;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_d_q  <= gnt_d;
`endif
          end
        end
        ISSUE: begin
          cnt_q <= 8'd0;
        end
        WAIT: begin
          if (mem_valid) begin
            err_q <= 1'b0;
            // Writes also return mem_result, as the RAM reports it.
            if (owner_d_q) d_rdata <= mem_result;
            else           i_rdata <= mem_result;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a reference model

module tb_ram_port_arbiter;

  localparam int          T    = 15;
  localparam logic [31:0] MMIO = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  i_oplen = '0, d_oplen = '0;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_enable, mem_we;
  logic [31:0] mem_addr, mem_data;
  logic [1:0]  mem_oplen;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_result = '0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.TIMEOUT_CYCLES(T), .MMIO_ADDR(MMIO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_oplen(i_oplen),
    .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_oplen(d_oplen),
    .d_we(d_we), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_oplen(mem_oplen),
    .mem_we(mem_we), .mem_data(mem_data),
    .mem_valid(mem_valid), .mem_result(mem_result)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Default RAM contents, used by the RAM model and the reference alike
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // RAM model: answers one cycle after mem_enable unless withhold is set.
  // inject forces a stray mem_valid pulse.
  logic [31:0] ram [logic [31:0]];
  bit withhold = 1'b0;
  bit inject   = 1'b0;

  initial begin
    bit          pend;
    bit          pw;
    logic [31:0] pa, pd;
    pend = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(posedge clk); #2;
      mem_valid  = 1'b0;
      mem_result = '0;
      if (pend) begin
        if (pw) ram[pa] = pd;
        mem_valid  = 1'b1;
        mem_result = ram.exists(pa) ? ram[pa] : ram_init(pa);
      end else if (inject) begin
        mem_valid  = 1'b1;
        mem_result = 32'hBAD0BAD0;
      end
      pend = mem_enable && !withhold;
      pa = mem_addr; pw = mem_we; pd = mem_data;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_last_d = 1'b0;
  logic [31:0] ref_ird = '0, ref_drd = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ram_init(a);
  endfunction

  function automatic bit bad(input logic [31:0] a, input logic [1:0] o);
    if (o == 2'd3) return 1'b1;
    if (a == MMIO) return 1'b0;
    if (o == 2'd1) return a % 2 != 0;
    if (o == 2'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic bit pick(input bit ri, input bit rd);
    if (ri && rd) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      return !ref_last_d;
`else
      return 1'b1;
`endif
    end
    return rd;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit keep, output int cyc, output bit who, output bit err,
                           output logic [31:0] rd, output int ena);
    cyc = 0; ena = 0; who = 0; err = 0; rd = '0;
    repeat (40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_enable) ena++;
      if (i_done || d_done) begin
        chk("one_done_only", {31'b0, i_done & d_done}, 32'd0);
        who = d_done;
        err = d_done ? d_err : i_err;
        rd  = d_done ? d_rdata : i_rdata;
        if (!keep) begin
          if (d_done) d_req = 1'b0;
          else        i_req = 1'b0;
        end
        return;
      end
    end
    cyc = -1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Predicts the next grant from the current requests. Then waits for it to
  // complete and compares the result against the model.
  task automatic serve(input string tag, input bit keep, input int extra);
    bit          w, e_err, we;
    logic [31:0] a, wd, e_rd;
    logic [1:0]  o;
    int          cyc, ena;
    bit          who, err;
    logic [31:0] rd;
    w  = pick(i_req, d_req);
    a  = w ? d_addr : i_addr;
    o  = w ? d_oplen : i_oplen;
    we = w && d_we;
    wd = d_wdata;
    e_err = bad(a, o);
    if (e_err)   e_rd = w ? ref_drd : ref_ird;
    else if (we) begin e_rd = wd; ref_mem[a] = wd; end
    else         e_rd = ref_read(a);
    if (w) ref_drd = e_rd; else ref_ird = e_rd;
    ref_last_d = w;
    wait_done(keep, cyc, who, err, rd, ena);
    chk({tag, ".port"},    {31'b0, who}, {31'b0, w});
    chk({tag, ".err"},     {31'b0, err}, {31'b0, e_err});
    chk({tag, ".rdata"},   rd, e_rd);
    chk({tag, ".latency"}, 32'(cyc), 32'((e_err ? 1 : 3) + extra));
    chk({tag, ".enables"}, 32'(ena), e_err ? 32'd0 : 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return MMIO;
    a = 32'($urandom_range(0, 255));
    if (r > 3) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int          cyc, ena, mode;
    bit          who, err;
    logic [31:0] rd;

    ram[32'h10]     = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;

    // Reset state
    repeat (3) step();
    chk("reset.ctrl", {26'b0, mem_enable, i_done, d_done, i_err, d_err, mem_we}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.i_rdata", i_rdata, 32'd0);
    rst = 1'b1;
    step();

    // Single I word read
    i_addr = 32'h10; i_oplen = 2'd2; i_req = 1'b1;
    serve("t1", 1'b0, 0);
    chk("t1.mem_addr_hold", mem_addr, 32'h10);
    step();

    // D byte write to the GPIO address, then read it back
    d_addr = MMIO; d_oplen = 2'd0; d_we = 1'b1; d_wdata = 32'h1234; d_req = 1'b1;
    serve("t2w", 1'b0, 0);
    chk("t2.mem_we", {31'b0, mem_we}, 32'd1);
    chk("t2.mem_data", mem_data, 32'h1234);
    step();
    d_we = 1'b0; d_req = 1'b1;
    serve("t2r", 1'b0, 0);
    chk("t2.readback", d_rdata, 32'h00001234);
    step();

    // Misaligned word and reserved size
    d_addr = 32'h6; d_oplen = 2'd2; d_req = 1'b1;
    serve("t3a", 1'b0, 0);
    step();
    d_addr = 32'h8; d_oplen = 2'd3; d_req = 1'b1;
    serve("t3b", 1'b0, 0);
    step();

    // Contention: both held for four grants
    i_addr = 32'h20; i_oplen = 2'd2; d_addr = 32'h30; d_oplen = 2'd2; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    serve("t4.0", 1'b1, 0);
    serve("t4.1", 1'b1, 1);
    serve("t4.2", 1'b1, 1);
    serve("t4.3", 1'b1, 1);
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Timeout, stray mem_valid, then recovery
    withhold = 1'b1;
    i_addr = 32'h40; i_oplen = 2'd2; i_req = 1'b1;
    ref_last_d = 1'b0;
    wait_done(1'b0, cyc, who, err, rd, ena);
    chk("t5.latency", 32'(cyc), 32'(T + 2));
    chk("t5.port", {31'b0, who}, 32'd0);
    chk("t5.err", {31'b0, err}, 32'd1);
    chk("t5.rdata_kept", rd, ref_ird);
    withhold = 1'b0;
    step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) begin
      step();
      chk("t5.no_stray_done", {30'b0, i_done, d_done}, 32'd0);
    end
    i_addr = 32'h44; i_req = 1'b1;
    serve("t5.next", 1'b0, 0);
    step();

    // Asynchronous reset while waiting on the RAM
    withhold = 1'b1;
    d_addr = 32'h50; d_oplen = 2'd2; d_we = 1'b0; d_req = 1'b1;
    repeat (3) step();
    #2; rst = 1'b0; #1;
    chk("t6.ctrl", {24'b0, mem_enable, i_done, d_done, i_err, d_err, mem_we, mem_oplen}, 32'd0);
    chk("t6.mem_addr", mem_addr, 32'd0);
    chk("t6.mem_data", mem_data, 32'd0);
    chk("t6.i_rdata", i_rdata, 32'd0);
    d_req = 1'b0;
    withhold = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    ref_ird = '0; ref_drd = '0; ref_last_d = 1'b0;
    repeat (5) begin
      step();
      chk("t6.no_stale_done", {30'b0, i_done, d_done}, 32'd0);
    end

    // Randomized accesses against the model
    for (int n = 0; n < 24; n++) begin
      mode    = $urandom_range(0, 2);
      i_addr  = rand_addr();
      i_oplen = 2'($urandom_range(0, 3));
      d_addr  = rand_addr();
      d_oplen = 2'($urandom_range(0, 3));
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      i_req   = (mode != 1);
      d_req   = (mode != 0);
      serve($sformatf("rnd%0d.a", n), 1'b0, 0);
      if (mode == 2) serve($sformatf("rnd%0d.b", n), 1'b0, 1);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
